// File: rtl/qam64_mapper.sv
// 64-QAM mapper: packs a byte stream into 6-bit Gray-coded I/Q symbols with subcarrier indexing.
// Latency: a byte accepted on edge k yields its first symbol on the outputs after edge k+1.
// Backpressure: in_ready comes from buffer occupancy only; the output register holds while out_ready is low.
module qam64_mapper #(
  parameter int W     = 16,
  parameter int N     = 8,
  parameter int SCALE = 1024
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] i_out,
  output logic [W-1:0] q_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   sc_index,
  output logic         out_last
);

  // Bit buffer is MSB-aligned: bit_buf[15] is the oldest bit. Bits at or
  // beyond the occupancy count are always zero, so a new byte can be ORed in.
  logic [15:0] bit_buf;
  logic [4:0]  count;
  logic [2:0]  sc_next;

  logic        push;
  logic        load;
  logic [4:0]  rem;
  logic [15:0] buf_nxt;
  logic [4:0]  count_nxt;

  // Gray-coded 3-bit group to signed amplitude: gray->binary, then 2*b-7.
  function automatic logic [W-1:0] gray_level(input logic [2:0] g);
    logic [2:0] b;
    int         v;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    v    = (2 * int'(b) - 7) * SCALE;
    return v[W-1:0];
  endfunction

  // Accept bytes only while the remaining space can take a full byte.
  assign in_ready = (count <= 5'd8);
  assign push     = in_valid && in_ready;
  // Load a symbol when six bits are available and the output slot is free or draining.
  assign load     = (count >= 5'd6) && (!out_valid || out_ready);

  // Next buffer contents: drop the consumed symbol, then append the new byte behind what remains.
  always_comb begin
    rem     = load ? (count - 5'd6) : count;
    buf_nxt = load ? {bit_buf[9:0], 6'b000000} : bit_buf;
    if (push) begin
      buf_nxt = buf_nxt | ({in_data, 8'h00} >> rem);
    end
    count_nxt = rem + (push ? 5'd8 : 5'd0);
  end

  // Buffer and occupancy registers.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      bit_buf <= 16'h0000;
      count   <= 5'd0;
    end else begin
      bit_buf <= buf_nxt;
      count   <= count_nxt;
    end
  end

  // Output symbol register with its subcarrier tag; held while stalled downstream.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      i_out     <= '0;
      q_out     <= '0;
      sc_index  <= 3'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      sc_next   <= 3'd0;
    end else if (load) begin
      i_out     <= gray_level(bit_buf[15:13]);
      q_out     <= gray_level(bit_buf[12:10]);
      sc_index  <= sc_next;
      out_last  <= (sc_next == 3'(N - 1));
      out_valid <= 1'b1;
      sc_next   <= (sc_next == 3'(N - 1)) ? 3'd0 : sc_next + 3'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qam64_mapper.sv
// Bench for qam64_mapper: bit-queue reference model checked every cycle,
// plus directed frames with hand-computed amplitudes.
module tb_qam64_mapper;
  localparam int W     = 16;
  localparam int N     = 8;
  localparam int SCALE = 1024;

  logic         aclk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] i_out;
  logic [W-1:0] q_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   sc_index;
  logic         out_last;

  int checks = 0;
  int errors = 0;

  qam64_mapper #(.W(W), .N(N), .SCALE(SCALE)) dut (
    .aclk(aclk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .i_out(i_out), .q_out(q_out), .out_valid(out_valid),
    .out_ready(out_ready), .sc_index(sc_index), .out_last(out_last)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Amplitude per Gray-coded group, indexed by the 3 raw bits.
  int lv [8] = '{-7, -5, -1, -3, 7, 5, 1, 3};

  // Reference model: a plain queue of pending bits plus the current output symbol.
  int mq[$];
  bit mv;
  int m_i, m_q, m_sc, m_last, m_scn;

  always @(posedge aclk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mv = 0; m_i = 0; m_q = 0; m_sc = 0; m_last = 0; m_scn = 0;
    end else begin
      bit push, load;
      int g [6];
      push = in_valid && (mq.size() <= 8);
      load = (mq.size() >= 6) && (!mv || out_ready);
      if (load) begin
        for (int k = 0; k < 6; k++) g[k] = mq.pop_front();
        m_i    = lv[g[0]*4 + g[1]*2 + g[2]] * SCALE;
        m_q    = lv[g[3]*4 + g[4]*2 + g[5]] * SCALE;
        m_sc   = m_scn;
        m_last = (m_scn == N - 1);
        m_scn  = (m_scn + 1) % N;
        mv     = 1;
      end else if (out_ready) begin
        mv = 0;
      end
      if (push) begin
        for (int k = 7; k >= 0; k--) mq.push_back(int'(in_data[k]));
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge aclk) begin
    if (!reset) begin
      chk("in_ready", int'(in_ready), int'(mq.size() <= 8));
      chk("out_valid", int'(out_valid), int'(mv));
      if (mv) begin
        chk("i_out", int'($signed(i_out)), m_i);
        chk("q_out", int'($signed(q_out)), m_q);
        chk("sc_index", int'(sc_index), m_sc);
        chk("out_last", int'(out_last), m_last);
      end
    end
  end

  // Transfer and acceptance capture for directed tests.
  int cap_i[$], cap_q[$], cap_sc[$], cap_last[$];
  int acc;
  always @(posedge aclk or posedge reset) begin
    if (reset) begin
      cap_i.delete(); cap_q.delete(); cap_sc.delete(); cap_last.delete();
      acc = 0;
    end else begin
      if (out_valid && out_ready) begin
        cap_i.push_back(int'($signed(i_out)));
        cap_q.push_back(int'($signed(q_out)));
        cap_sc.push_back(int'(sc_index));
        cap_last.push_back(int'(out_last));
      end
      if (in_valid && in_ready) acc++;
    end
  end

  task automatic do_reset();
    @(negedge aclk);
    in_valid = 0;
    out_ready = 0;
    reset = 1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_i_out", int'(i_out), 0);
    chk("rst_q_out", int'(q_out), 0);
    chk("rst_sc_index", int'(sc_index), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge aclk);
    reset = 0;
    @(posedge aclk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [7:0] b);
    int t = 0;
    in_data = b;
    in_valid = 1;
    while (!in_ready && t < 200) begin
      @(posedge aclk); #1;
      t++;
    end
    if (t >= 200) chk("send_timeout", 0, 1);
    @(posedge aclk); #1;
  endtask

  task automatic wait_cap(input int n);
    int t = 0;
    while (cap_i.size() < n && t < 100) begin
      @(posedge aclk); #1;
      t++;
    end
    chk("cap_count", cap_i.size() >= n ? 1 : 0, 1);
  endtask

  task automatic frame3(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int amp);
    do_reset();
    out_ready = 1;
    send(b0);
    chk("lat_before", int'(out_valid), 0);
    send(b1);
    chk("lat_after", int'(out_valid), 1);
    send(b2);
    in_valid = 0;
    wait_cap(4);
    repeat (4) @(posedge aclk);
    #1;
    chk("frame_syms", cap_i.size(), 4);
    for (int k = 0; k < 4 && k < cap_i.size(); k++) begin
      chk("frame_i", cap_i[k], amp);
      chk("frame_q", cap_q[k], amp);
      chk("frame_sc", cap_sc[k], k);
    end
  endtask

  initial begin
    logic [7:0] r;
    repeat (2) @(posedge aclk);
    #1;
    do_reset();

    // Hand-computed frames.
    frame3(8'h00, 8'h00, 8'h00, -7168);
    frame3(8'h92, 8'h49, 8'h24, 7168);
    frame3(8'hFF, 8'hFF, 8'hFF, 3072);

    // Stalled output: exactly two bytes fit before in_ready drops.
    do_reset();
    in_data = 8'hFF;
    in_valid = 1;
    repeat (10) @(posedge aclk);
    #1;
    chk("stall_acc", acc, 2);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_out_valid", int'(out_valid), 1);
    chk("stall_i", int'($signed(i_out)), 3072);
    repeat (5) @(posedge aclk);
    #1;
    chk("stall_hold_i", int'($signed(i_out)), 3072);
    chk("stall_hold_sc", int'(sc_index), 0);
    in_valid = 0;
    out_ready = 1;
    repeat (10) @(posedge aclk);
    #1;

    // Full frame of 8 symbols with out_last on index 7, then wrap.
    do_reset();
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      r = 8'($urandom);
      send(r);
    end
    in_valid = 0;
    wait_cap(8);
    for (int k = 0; k < 8 && k < cap_sc.size(); k++) begin
      chk("full_sc", cap_sc[k], k);
      chk("full_last", cap_last[k], (k == 7) ? 1 : 0);
    end
    send(8'h5A);
    in_valid = 0;
    wait_cap(9);
    if (cap_sc.size() >= 9) chk("wrap_sc", cap_sc[8], 0);

    // Reset in the middle of a frame.
    do_reset();
    out_ready = 1;
    send(8'h12); send(8'h34); send(8'h56);
    in_valid = 0;
    wait_cap(2);
    #3;
    reset = 1;
    #1;
    chk("mid_out_valid", int'(out_valid), 0);
    chk("mid_i_out", int'(i_out), 0);
    chk("mid_q_out", int'(q_out), 0);
    chk("mid_sc_index", int'(sc_index), 0);
    chk("mid_out_last", int'(out_last), 0);
    chk("mid_in_ready", int'(in_ready), 1);
    @(negedge aclk);
    reset = 0;
    @(posedge aclk); #1;
    send(8'hA5); send(8'h3C); send(8'hC3);
    in_valid = 0;
    wait_cap(4);
    for (int k = 0; k < 4 && k < cap_sc.size(); k++) chk("post_rst_sc", cap_sc[k], k);

    // Randomized traffic with random backpressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge aclk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (10) @(posedge aclk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qam64_mapper.md
QAM64_MAPPER -- requirements
Module: qam64_mapper

Interface
REQ-001 SHALL have parameter W, default 16, I/Q output sample width in bits (two's complement).
REQ-002 SHALL have parameter N, default 8, subcarrier symbols per OFDM frame.
REQ-003 SHALL have parameter SCALE, default 1024, output amplitude of unit level.
REQ-004 SHALL have port aclk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_data  input  8  payload byte from the source generator.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  mapper accepts a byte this cycle.
REQ-009 SHALL have port i_out  output  W  in-phase sample.
REQ-010 SHALL have port q_out  output  W  quadrature sample.
REQ-011 SHALL have port out_valid  output  1  i_out/q_out/sc_index/out_last valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the current symbol.
REQ-013 SHALL have port sc_index  output  3  subcarrier index of current symbol, 0..N-1.
REQ-014 SHALL have port out_last  output  1  high when sc_index == N-1.

Function
REQ-015 SHALL accept a byte on an edge where in_valid && in_ready; produce a symbol transfer on an edge where out_valid && out_ready.
REQ-016 SHALL hold a 16-bit bit buffer with occupancy count 0..16; bits consumed MSB-first in arrival order (in_data[7] first).
REQ-017 SHALL drive in_ready = (count <= 8), from registered count only, no combinational path from out_ready or in_valid.
REQ-018 SHALL load the output register from the 6 oldest buffer bits b5..b0 when count >= 6 and (!out_valid || out_ready).
REQ-019 SHALL update count' = count + 8*push - 6*load on each edge; simultaneous push and load both take effect; new byte lands behind remaining bits.
REQ-020 SHALL map b5b4b3 to I and b2b1b0 to Q with Gray code: 000=-7, 001=-5, 011=-3, 010=-1, 110=+1, 111=+3, 101=+5, 100=+7, each multiplied by SCALE, sign-extended to W.
REQ-021 SHALL hold i_out, q_out, sc_index, out_last stable while out_valid && !out_ready.
REQ-022 SHALL deassert out_valid after a transfer when no new load occurs on the same edge.
REQ-023 SHALL increment sc_index on each output transfer, wrapping N-1 -> 0; sc_index on the output register reflects the symbol it carries.
REQ-024 SHALL have latency: byte accepted on edge k -> its first symbol on outputs with out_valid=1 after edge k+1 (if output register free).
REQ-025 SHALL sustain 4 symbols per 3 bytes with no bubbles when in_valid and out_ready held high.
REQ-026 SHALL drop no bits and emit no partial symbol; residual bits (<6) remain buffered indefinitely.

Reset
REQ-027 SHALL on reset clear count, bit buffer, i_out, q_out, sc_index to 0 and out_valid, out_last to 0; in_ready=1 immediately after reset.
REQ-028 SHALL on reset mid-frame discard buffered bits and pending symbol; next frame starts at sc_index 0.

Verification
REQ-029 SHALL cover: bytes 0x00,0x00,0x00, out_ready=1 -> 4 symbols, I=Q=0xE400 (-7168), sc_index 0,1,2,3.
REQ-030 SHALL cover: bytes 0x92,0x49,0x24 -> 4 symbols, I=Q=0x1C00 (+7168).
REQ-031 SHALL cover: bytes 0xFF x3 -> 4 symbols, I=Q=0x0C00 (+3072).
REQ-032 SHALL cover: out_ready=0, in_valid=1 from reset -> exactly 2 bytes accepted, then in_ready=0, out_valid=1 holding the first symbol stable.
REQ-033 SHALL cover: 6 continuous bytes, out_ready=1 -> 8 symbols back-to-back, out_last=1 only on sc_index=7, next symbol at sc_index 0.
REQ-034 SHALL cover: reset asserted after 2 symbols of a frame -> all outputs 0 asynchronously; fresh 3 bytes give sc_index 0..3.
